// File: rtl/hazard_pipe_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use stall,
// mul/div wait, branch flush, interrupt entry and debug single-step sequencing.
module hazard_pipe_ctrl #(
  parameter  int NSTG     = 2,
  parameter  int AW       = 5,
  parameter  int BR_FLUSH = 2,
  parameter  int MD_LAT   = 4,
  localparam int FW       = $clog2(NSTG + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rs_used,
  input  logic                 rt_used,
  input  logic [AW-1:0]        addr_rs,
  input  logic [AW-1:0]        addr_rt,
  input  logic [NSTG*AW-1:0]   pw_addr,
  input  logic [NSTG-1:0]      pw_wen,
  input  logic [NSTG-1:0]      pw_load,
  output logic [FW-1:0]        fwd_s,
  output logic [FW-1:0]        fwd_t,
  input  logic                 jump_id,
  input  logic                 mispredict,
  input  logic                 md_start,
  output logic                 md_busy,
  input  logic                 irq,
  input  logic                 status_ie,
  input  logic                 debug_en,
  input  logic                 debug_step,
  output logic [4:0]           stage_en,
  output logic [4:0]           stage_rst,
  output logic                 epc_wen,
  output logic                 status_set,
  output logic                 pc_vector
);

  localparam int MW  = $clog2(MD_LAT + 1);
  localparam int FLW = $clog2(BR_FLUSH + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    IRQ_TAKE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic           irq_pend, irq_pend_nxt;
  logic [MW-1:0]  md_cnt, md_cnt_nxt;
  logic [FLW-1:0] fl_cnt, fl_cnt_nxt;
  logic           step_prev;
  logic           step_go;
  logic           irq_req;

  // Returns {load_hit, select}; the nearest writing stage wins, and a load
  // still in EXE (stage 0) cannot supply data yet.
  function automatic logic [FW:0] fwd_pick(
    input logic                used,
    input logic [AW-1:0]       addr,
    input logic [NSTG*AW-1:0]  pa,
    input logic [NSTG-1:0]     wen,
    input logic [NSTG-1:0]     ld
  );
    logic [FW:0] r;
    logic        hit;
    r   = '0;
    hit = 1'b0;
    if (used && (addr != '0)) begin
      for (int k = 0; k < NSTG; k++) begin
        if (!hit && wen[k] && (pa[k*AW +: AW] == addr)) begin
          hit         = 1'b1;
          r[FW-1:0]   = FW'(k + 1);
          r[FW]       = ld[k] && (k == 0);
        end
      end
    end
    return r;
  endfunction

  logic [FW:0] pick_s, pick_t;
  logic        load_stall;

  always_comb begin
    pick_s     = fwd_pick(rs_used, addr_rs, pw_addr, pw_wen, pw_load);
    pick_t     = fwd_pick(rt_used, addr_rt, pw_addr, pw_wen, pw_load);
    load_stall = pick_s[FW] | pick_t[FW];
    fwd_s      = load_stall ? '0 : pick_s[FW-1:0];
    fwd_t      = load_stall ? '0 : pick_t[FW-1:0];
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      irq_pend  <= 1'b0;
      md_cnt    <= '0;
      fl_cnt    <= '0;
      step_prev <= 1'b0;
    end else begin
      state     <= state_nxt;
      irq_pend  <= irq_pend_nxt;
      md_cnt    <= md_cnt_nxt;
      fl_cnt    <= fl_cnt_nxt;
      step_prev <= debug_step;
    end
  end

  // A request arriving this cycle is honoured at the same edge it is sampled.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    irq_req    = irq_pend | (irq & status_ie);
    case (state)
      RUN: begin
        if (irq_req) begin
          state_nxt = IRQ_TAKE;
        end else if (md_start) begin
          state_nxt  = MD_WAIT;
          md_cnt_nxt = MW'(MD_LAT - 1);
        end
      end
      MD_WAIT: begin
        md_cnt_nxt = md_cnt - 1'b1;
        if (md_cnt == MW'(1)) begin
          state_nxt = irq_req ? IRQ_TAKE : RUN;
        end
      end
      IRQ_TAKE: state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
    irq_pend_nxt = (state_nxt == IRQ_TAKE) ? 1'b0 : irq_req;
  end

  always_comb begin
    fl_cnt_nxt = fl_cnt;
    if (mispredict) begin
      fl_cnt_nxt = '0;
    end else if (jump_id && ((state == RUN) || (fl_cnt != '0))) begin
      fl_cnt_nxt = FLW'(BR_FLUSH);
    end else if (fl_cnt != '0) begin
      fl_cnt_nxt = fl_cnt - 1'b1;
    end
  end

  assign step_go = debug_step & ~step_prev;
  assign md_busy = (state == MD_WAIT);

  // Stage enable/reset arbitration, highest priority first.
  always_comb begin
    stage_en   = 5'b11111;
    stage_rst  = 5'b00000;
    epc_wen    = 1'b0;
    status_set = 1'b0;
    pc_vector  = 1'b0;
    if (!rst_n) begin
      stage_rst = 5'b11111;
    end else if (state == IRQ_TAKE) begin
      stage_en   = 5'b10000;
      stage_rst  = 5'b01111;
      epc_wen    = 1'b1;
      status_set = 1'b1;
      pc_vector  = 1'b1;
    end else if (debug_en && !step_go) begin
      stage_en = 5'b00000;
    end else if (state == MD_WAIT) begin
      stage_en[2:0] = 3'b000;
      stage_rst[3]  = 1'b1;
    end else if (mispredict) begin
      stage_rst[2:1] = 2'b11;
    end else if (load_stall) begin
      stage_en[1:0] = 2'b00;
      stage_rst[2]  = 1'b1;
    end else if (jump_id || (fl_cnt != '0)) begin
      stage_en[0]  = 1'b0;
      stage_rst[1] = 1'b1;
    end
  end

endmodule

// File: doc/hazard_pipe_ctrl.md
# hazard_pipe_ctrl

Parametrised pipeline-control successor for the 5-stage MIPS core: one block that generates forwarding selects over a configurable number of producer stages, detects load-use hazards, and sequences stalls, flushes and multicycle mul/div waits. It also runs a registered interrupt-entry FSM and debug single-step. It sits beside the ID stage, drives the per-stage enable/reset pairs, and replaces the fixed two-stage forwarding and branch-stall logic of the previous controller.

## Interface
Parameters:
- NSTG, 2, producer stages after ID that can forward (index 0 = EXE, 1 = MEM, …); legal range 1..6
- AW, 5, register address width
- BR_FLUSH, 2, bubbles inserted into ID after an ID-decoded jump/JR/ERET; legal range 1..7
- MD_LAT, 4, mul/div busy cycles, including the issue cycle; legal range 2..15

Ports (FW = $clog2(NSTG+1)):
- clk  in  1  main clock
- rst_n  in  1  asynchronous, active-low reset
- rs_used, rt_used  in  1  ID instruction reads rs / rt
- addr_rs, addr_rt  in  AW  ID source registers
- pw_addr  in  NSTG*AW  destination of stage k, packed at [k*AW +: AW]
- pw_wen  in  NSTG  stage k writes the GPR
- pw_load  in  NSTG  stage k holds a load
- fwd_s, fwd_t  out  FW  0 = register file; k+1 = forward from stage k
- jump_id  in  1  unconditional jump/JR/ERET in ID
- mispredict  in  1  branch misprediction resolved in EXE
- md_start  in  1  mul/div issuing in EXE
- md_busy  out  1  mul/div counter nonzero
- irq, status_ie  in  1  interrupt request; interrupt enable
- debug_en, debug_step  in  1  halt mode; step pulse (level, edge-detected)
- stage_en, stage_rst  out  5  bit 0 = IF … bit 4 = WB
- epc_wen, status_set, pc_vector  out  1  interrupt entry strobes

## Operation
- Forwarding:
  - A source forwards only when it is used and its address is nonzero.
  - Scan stage 0 → NSTG-1; the first stage with pw_wen set and a matching address wins.
  - A winning stage 0 with pw_load set raises load_stall instead of forwarding.
  - A winning stage ≥1 that holds a load forwards normally.
  - When load_stall is set, fwd_s and fwd_t are forced to 0.
- FSM states: RUN, MD_WAIT, IRQ_TAKE.
  - irq_pend register: set by irq&status_ie, cleared on entry to IRQ_TAKE.
  - RUN → IRQ_TAKE when irq_pend & ~md_busy.
  - RUN → MD_WAIT on md_start. The counter loads MD_LAT-1.
  - MD_WAIT: the counter decrements each cycle. At 1 the FSM returns to RUN, or goes to IRQ_TAKE if irq_pend. md_start in MD_WAIT is ignored.
  - IRQ_TAKE lasts 1 cycle, then RUN.
- Flush counter:
  - jump_id in RUN loads BR_FLUSH. The counter decrements while nonzero.
  - jump_id while the counter is nonzero reloads it.
  - mispredict clears it.
- Debug: step_prev register; step_go = debug_step & ~step_prev.
- Output priority (first match wins). Defaults: stage_en=5'b11111, stage_rst=0, strobes=0.
  1. rst_n low: stage_rst=5'b11111.
  2. IRQ_TAKE: stage_en=5'b10000, stage_rst=5'b01111, epc_wen=status_set=pc_vector=1.
  3. debug_en & ~step_go: stage_en=0.
  4. MD_WAIT: stage_en[2:0]=0, stage_rst[3]=1.
  5. mispredict: stage_rst[2:1]=1.
  6. load_stall: stage_en[1:0]=0, stage_rst[2]=1.
  7. jump_id or flush counter ≠0: stage_en[0]=0, stage_rst[1]=1.
- md_busy = (state==MD_WAIT).
- Reset values: state RUN, irq_pend 0, both counters 0, step_prev 0. All strobes 0 and md_busy 0 during reset.

## Timing
- Forwarding and stall decisions are combinational from ID-stage inputs in the same cycle.
- Interrupt: irq sampled at edge N → epc_wen high during cycle N+1, provided RUN and not busy.
- MD: md_start at edge N → md_busy high for cycles N+1 … N+MD_LAT-1.
- Jump: the jump cycle plus BR_FLUSH following cycles have stage_rst[1]=1.
- Debug: each debug_step rising edge advances the pipeline exactly 1 cycle.
- Async reset: rst_n falling mid-MD_WAIT or mid-IRQ_TAKE returns the FSM to RUN with no clock. Pending irq is lost.

## Test plan
- NSTG=3: addr_rs=5, pw_addr={5,5,5}, pw_wen=3'b110 → fwd_s=2 (stage 1). Then addr_rs=0 → fwd_s=0.
- Load-use: pw_load[0]=1, pw_addr[0]=rt=7, rt_used=1 → stage_en=5'b11100, stage_rst=5'b00100, fwd_t=0.
- MD_LAT=4: md_start pulse → md_busy high 3 cycles; stage_rst[3]=1 each of those cycles; irq during busy → epc_wen 1 cycle after md_busy falls.
- BR_FLUSH=2: jump_id 1 cycle → stage_rst[1] high 3 consecutive cycles; mispredict in the 2nd cycle → stage_rst=5'b00110, counter cleared.
- debug_en=1: stage_en=0 until debug_step 0→1, then 5'b11111 for exactly 1 cycle.
- rst_n low mid-MD_WAIT → stage_rst=5'b11111 immediately, md_busy=0, RUN after release.
